// File: rtl/trap_ctrl_if.sv
// Signal bundle between the retire stage, the CSR file and the trap controller.
// The controller sits on the slave side; whoever drives the retire/CSR inputs is the master.
interface trap_ctrl_if;
    logic        retire_valid_i;
    logic [31:0] retire_addr_i;
    logic        ecall_i;
    logic        illegal_i;
    logic        mret_i;
    logic        stallreq_i;
    logic        ext_int_i;
    logic        timer_int_i;
    logic [31:0] mstatus_i;
    logic [31:0] mie_i;
    logic [31:0] mtvec_i;
    logic [31:0] mepc_i;
    logic [31:0] excepttype_o;
    logic [31:0] inst_addr_o;
    logic        stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;

    modport master (
        output retire_valid_i, retire_addr_i, ecall_i, illegal_i, mret_i, stallreq_i,
        output ext_int_i, timer_int_i, mstatus_i, mie_i, mtvec_i, mepc_i,
        input  excepttype_o, inst_addr_o, stall_o, flush_o, new_pc_o
    );

    modport slave (
        input  retire_valid_i, retire_addr_i, ecall_i, illegal_i, mret_i, stallreq_i,
        input  ext_int_i, timer_int_i, mstatus_i, mie_i, mtvec_i, mepc_i,
        output excepttype_o, inst_addr_o, stall_o, flush_o, new_pc_o
    );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap arbitration: picks one exception/interrupt per accepted retirement,
// presents the cause to the CSR file for one cycle, then flushes and redirects the pipeline.
module trap_ctrl #(
    parameter int SYNC_STAGES  = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    trap_ctrl_if.slave  tc
);
    typedef enum logic [1:0] {IDLE, TRAP, JUMP} state_t;

    localparam int              CW        = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LOAD  = CW'(FLUSH_CYCLES - 1);
    localparam logic [31:0]     CAUSE_ILL = 32'h0000_0002;
    localparam logic [31:0]     CAUSE_ECL = 32'h0000_000B;
    localparam logic [31:0]     CAUSE_MRT = 32'h0000_000A;
    localparam logic [31:0]     CAUSE_EXT = 32'h8000_000B;
    localparam logic [31:0]     CAUSE_TMR = 32'h8000_0007;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [31:0]          cause_q, cause_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          pc_q, pc_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 ext_s, ext_en, tmr_en, accept;
    logic [31:0]          win_cause;
    logic                 unused_csr_bits;

    assign unused_csr_bits = ^{tc.mstatus_i[31:4], tc.mstatus_i[2:0],
                               tc.mie_i[31:12], tc.mie_i[10:8], tc.mie_i[6:0]};

    function automatic logic [31:0] redirect(input logic [31:0] cause,
                                             input logic [31:0] mtvec,
                                             input logic [31:0] mepc);
        logic [31:0] base;
        base = {mtvec[31:2], 2'b00};
        if (cause == CAUSE_MRT)
            return mepc;
        if (cause[31] && (mtvec[1:0] == 2'b01))
            return base + {26'd0, cause[3:0], 2'b00};
        return base;
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            sync_q <= '0;
        else
            sync_q <= {sync_q[SYNC_STAGES-2:0], tc.ext_int_i};
    end

    assign ext_s  = sync_q[SYNC_STAGES-1];
    assign ext_en = ext_s & tc.mstatus_i[3] & tc.mie_i[11];
    assign tmr_en = tc.timer_int_i & tc.mstatus_i[3] & tc.mie_i[7];
    assign accept = tc.retire_valid_i & ~tc.stallreq_i;

    always_comb begin
        win_cause = '0;
        if (tc.illegal_i)     win_cause = CAUSE_ILL;
        else if (tc.ecall_i)  win_cause = CAUSE_ECL;
        else if (tc.mret_i)   win_cause = CAUSE_MRT;
        else if (ext_en)      win_cause = CAUSE_EXT;
        else if (tmr_en)      win_cause = CAUSE_TMR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        cause_q <= cause_d;
        addr_q  <= addr_d;
        pc_q    <= pc_d;
    end

    // The redirect target is sampled once, in the first JUMP cycle, after the CSR commit.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        cause_d         = cause_q;
        addr_d          = addr_q;
        pc_d            = pc_q;
        tc.excepttype_o = '0;
        tc.inst_addr_o  = '0;
        tc.stall_o      = 1'b0;
        tc.flush_o      = 1'b0;
        tc.new_pc_o     = '0;
        case (state_q)
            IDLE: begin
                if (accept && (win_cause != '0)) begin
                    cause_d = win_cause;
                    addr_d  = tc.retire_addr_i;
                    state_d = TRAP;
                end
            end
            TRAP: begin
                tc.excepttype_o = cause_q;
                tc.inst_addr_o  = addr_q;
                tc.stall_o      = 1'b1;
                cnt_d           = CNT_LOAD;
                state_d         = JUMP;
            end
            JUMP: begin
                tc.stall_o = 1'b1;
                tc.flush_o = 1'b1;
                if (cnt_q == CNT_LOAD)
                    pc_d = redirect(cause_q, tc.mtvec_i, tc.mepc_i);
                tc.new_pc_o = pc_d;
                if (cnt_q == '0)
                    state_d = IDLE;
                else
                    cnt_d = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios followed by random traffic, every cycle compared
// against a schedule-based reference model of the expected output sequence.
module tb_trap_ctrl;
    localparam int SYNC_STAGES  = 2;
    localparam int FLUSH_CYCLES = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    trap_ctrl_if tc ();

    trap_ctrl #(.SYNC_STAGES(SYNC_STAGES), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk (clk),
        .rst (rst),
        .tc  (tc.slave)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] etype;
        logic [31:0] addr;
        logic        jump;
        logic        first;
    } ent_t;

    ent_t        sched[$];
    logic        sync_m[$];
    logic [31:0] m_cause;
    logic [31:0] held_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pick_cause(input logic ext_s);
        if (tc.illegal_i) return 32'h0000_0002;
        if (tc.ecall_i)   return 32'h0000_000B;
        if (tc.mret_i)    return 32'h0000_000A;
        if (ext_s && tc.mstatus_i[3] && tc.mie_i[11])       return 32'h8000_000B;
        if (tc.timer_int_i && tc.mstatus_i[3] && tc.mie_i[7]) return 32'h8000_0007;
        return 32'h0;
    endfunction

    function automatic logic [31:0] target(input logic [31:0] cause, input logic [31:0] mtvec,
                                           input logic [31:0] mepc);
        logic [31:0] base;
        base = mtvec & 32'hFFFF_FFFC;
        if (cause == 32'h0000_000A) return mepc;
        if (cause[31] && (mtvec % 4 == 1)) return base + 4 * (cause % 16);
        return base;
    endfunction

    // One clock cycle: compare at mid-cycle, advance the model, land on the next negedge.
    task automatic step();
        logic [31:0] c;
        logic        ext_s;
        #1;
        if (sched.size() == 0) begin
            check("idle_etype", tc.excepttype_o, 32'h0);
            check("idle_addr",  tc.inst_addr_o,  32'h0);
            check("idle_stall", {31'd0, tc.stall_o}, 32'h0);
            check("idle_flush", {31'd0, tc.flush_o}, 32'h0);
            check("idle_newpc", tc.new_pc_o, 32'h0);
        end else if (!sched[0].jump) begin
            check("trap_etype", tc.excepttype_o, sched[0].etype);
            check("trap_addr",  tc.inst_addr_o,  sched[0].addr);
            check("trap_stall", {31'd0, tc.stall_o}, 32'h1);
            check("trap_flush", {31'd0, tc.flush_o}, 32'h0);
        end else begin
            if (sched[0].first) held_pc = target(m_cause, tc.mtvec_i, tc.mepc_i);
            check("jump_etype", tc.excepttype_o, 32'h0);
            check("jump_stall", {31'd0, tc.stall_o}, 32'h1);
            check("jump_flush", {31'd0, tc.flush_o}, 32'h1);
            check("jump_newpc", tc.new_pc_o, held_pc);
        end
        ext_s = sync_m[SYNC_STAGES-1];
        if (rst) begin
            sched.delete();
            for (int i = 0; i < SYNC_STAGES; i++) sync_m[i] = 1'b0;
        end else begin
            if (sched.size() != 0) begin
                void'(sched.pop_front());
            end else if (tc.retire_valid_i && !tc.stallreq_i) begin
                c = pick_cause(ext_s);
                if (c != 0) begin
                    m_cause = c;
                    sched.push_back('{etype: c, addr: tc.retire_addr_i, jump: 1'b0, first: 1'b0});
                    for (int i = 0; i < FLUSH_CYCLES; i++)
                        sched.push_back('{etype: 32'h0, addr: 32'h0, jump: 1'b1, first: (i == 0)});
                end
            end
            sync_m.push_front(tc.ext_int_i);
            void'(sync_m.pop_back());
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_in();
        tc.retire_valid_i = 1'b0;
        tc.ecall_i        = 1'b0;
        tc.illegal_i      = 1'b0;
        tc.mret_i         = 1'b0;
        tc.stallreq_i     = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < SYNC_STAGES; i++) sync_m.push_back(1'b0);
        m_cause = 0;
        held_pc = 0;
        idle_in();
        tc.ext_int_i = 0; tc.timer_int_i = 0;
        tc.mstatus_i = 0; tc.mie_i = 0; tc.mtvec_i = 32'h40; tc.mepc_i = 0;
        tc.retire_addr_i = 32'h100;
        tc.retire_valid_i = 1; tc.ecall_i = 1;
        rst = 1;
        @(negedge clk);

        // Reset held with a pending ECALL, then the first free cycle accepts it.
        repeat (3) step();
        rst = 0;
        step();
        idle_in();
        #1 check("rst_release_etype", tc.excepttype_o, 32'h0000_000B);
        check("ecall_addr", tc.inst_addr_o, 32'h100);
        step();
        #1 check("ecall_newpc", tc.new_pc_o, 32'h40);
        repeat (3) step();

        // Vectored timer interrupt, then the same with MIE clear.
        tc.mstatus_i = 32'h8; tc.mie_i = 32'h80; tc.timer_int_i = 1; tc.mtvec_i = 32'h41;
        tc.retire_addr_i = 32'h200; tc.retire_valid_i = 1;
        step();
        tc.retire_valid_i = 0;
        #1 check("timer_etype", tc.excepttype_o, 32'h8000_0007);
        step();
        #1 check("timer_newpc", tc.new_pc_o, 32'h5C);
        repeat (3) step();
        tc.mstatus_i = 0; tc.retire_valid_i = 1;
        step();
        tc.retire_valid_i = 0;
        #1 check("timer_masked", tc.excepttype_o, 32'h0);
        step();

        // Priority: illegal beats both interrupts; external beats timer.
        tc.mstatus_i = 32'h8; tc.mie_i = 32'h880; tc.ext_int_i = 1;
        repeat (SYNC_STAGES + 1) step();
        tc.illegal_i = 1; tc.retire_valid_i = 1;
        step();
        idle_in();
        #1 check("prio_illegal", tc.excepttype_o, 32'h0000_0002);
        step();
        #1 check("prio_illegal_pc", tc.new_pc_o, 32'h40);
        repeat (3) step();
        tc.retire_valid_i = 1;
        step();
        tc.retire_valid_i = 0;
        #1 check("prio_ext", tc.excepttype_o, 32'h8000_000B);
        step();
        #1 check("prio_ext_pc", tc.new_pc_o, 32'h6C);
        repeat (3) step();

        // External interrupt latency through the synchronizer.
        tc.ext_int_i = 0; tc.timer_int_i = 0; tc.mie_i = 32'h800;
        repeat (SYNC_STAGES + 2) step();
        tc.ext_int_i = 1; tc.retire_valid_i = 1;
        repeat (SYNC_STAGES) step();
        #1 check("ext_early", tc.excepttype_o, 32'h0);
        step();
        tc.retire_valid_i = 0; tc.ext_int_i = 0;
        #1 check("ext_late", tc.excepttype_o, 32'h8000_000B);
        repeat (5) step();

        // MRET held off by a bus stall.
        tc.mstatus_i = 0; tc.mie_i = 0; tc.mepc_i = 32'h104;
        tc.mret_i = 1; tc.retire_valid_i = 1; tc.stallreq_i = 1;
        repeat (4) step();
        tc.stallreq_i = 0;
        step();
        idle_in();
        #1 check("mret_etype", tc.excepttype_o, 32'h0000_000A);
        step();
        #1 check("mret_newpc", tc.new_pc_o, 32'h104);
        repeat (3) step();

        // Reset arriving in the first JUMP cycle.
        tc.ecall_i = 1; tc.retire_valid_i = 1;
        step();
        idle_in();
        step();
        rst = 1;
        #1 check("midrst_flush_before", {31'd0, tc.flush_o}, 32'h1);
        step();
        rst = 0;
        #1 check("midrst_flush", {31'd0, tc.flush_o}, 32'h0);
        check("midrst_stall", {31'd0, tc.stall_o}, 32'h0);
        step();

        // Random traffic, CSRs and lines changing every cycle.
        for (int n = 0; n < 400; n++) begin
            rst               = ($urandom_range(0, 49) == 0);
            tc.retire_valid_i = $urandom_range(0, 1);
            tc.stallreq_i     = ($urandom_range(0, 3) == 0);
            tc.illegal_i      = ($urandom_range(0, 5) == 0);
            tc.ecall_i        = ($urandom_range(0, 5) == 0);
            tc.mret_i         = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) tc.ext_int_i = ~tc.ext_int_i;
            tc.timer_int_i    = ($urandom_range(0, 2) == 0);
            tc.mstatus_i      = $urandom();
            tc.mie_i          = $urandom();
            tc.mtvec_i        = $urandom();
            tc.mepc_i         = $urandom();
            tc.retire_addr_i  = $urandom();
            step();
        end
        rst = 0;
        idle_in();
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
